// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: chooses the next PC, stalls fetch, arbitrates redirects
// and runs the I-cache miss handshake, including redirects taken while a fill is in flight.
module fetch_controller #(
  parameter int                    WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0]  PC_INITIAL = 32'h0000_1000,
  parameter logic [WORD_SIZE-1:0]  EXC_VECTOR = 32'h0000_2000,
  parameter int                    LINE_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] PC,
  input  logic                 ImemHit,
  input  logic                 ImemFillDone,
  output logic                 ImemFillReq,
  output logic [WORD_SIZE-1:0] ImemFillAddr,
  input  logic                 StallD,
  input  logic                 BranchTakenE,
  input  logic [WORD_SIZE-1:0] BranchTargetE,
  input  logic                 ExcRaise,
  input  logic                 EretM,
  input  logic [WORD_SIZE-1:0] EretTarget,
  output logic [WORD_SIZE-1:0] PCNext,
  output logic                 StallF,
  output logic                 FlushD,
  output logic                 FetchValid
);

  localparam logic [WORD_SIZE-1:0] LINE_MASK = ~(WORD_SIZE'(LINE_BYTES - 1));

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MISS,
    ST_MISS_R
  } state_e;

  state_e               state_q, state_d;
  logic                 fill_req_q, fill_req_d;
  logic [WORD_SIZE-1:0] fill_addr_q, fill_addr_d;
  logic [WORD_SIZE-1:0] pend_q, pend_d;

  logic                 redirect;
  logic [WORD_SIZE-1:0] rtarget;
  logic [WORD_SIZE-1:0] pc_plus4;

  assign redirect = ExcRaise | EretM | BranchTakenE;
  assign rtarget  = ExcRaise ? EXC_VECTOR :
                    EretM    ? EretTarget : BranchTargetE;
  assign pc_plus4 = PC + WORD_SIZE'(4);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d     = state_q;
    fill_req_d  = fill_req_q;
    fill_addr_d = fill_addr_q;
    pend_d      = pend_q;
    PCNext      = pc_plus4;
    StallF      = 1'b0;
    FlushD      = 1'b0;
    FetchValid  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          PCNext = rtarget;
          FlushD = 1'b1;
        end else if (!ImemHit) begin
          StallF      = 1'b1;
          state_d     = ST_MISS;
          fill_req_d  = 1'b1;
          fill_addr_d = PC & LINE_MASK;
        end else begin
          StallF     = StallD;
          FetchValid = 1'b1;
        end
      end

      ST_MISS: begin
        StallF = 1'b1;
        if (ImemFillDone) begin
          state_d    = ST_RUN;
          fill_req_d = 1'b0;
          if (redirect) begin
            PCNext = rtarget;
            StallF = 1'b0;
            FlushD = 1'b1;
          end
        end else if (redirect) begin
          pend_d  = rtarget;
          FlushD  = 1'b1;
          state_d = ST_MISS_R;
        end
      end

      ST_MISS_R: begin
        // The line being filled belongs to the squashed path; only the saved target matters.
        StallF = 1'b1;
        if (ImemFillDone) begin
          PCNext     = redirect ? rtarget : pend_q;
          StallF     = 1'b0;
          FlushD     = 1'b1;
          state_d    = ST_RUN;
          fill_req_d = 1'b0;
        end else if (redirect) begin
          pend_d = rtarget;
          FlushD = 1'b1;
        end
      end

      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      PCNext     = PC_INITIAL;
      StallF     = 1'b0;
      FlushD     = 1'b1;
      FetchValid = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; a fill in flight is simply abandoned.
      state_q     <= ST_RUN;
      fill_req_q  <= 1'b0;
      fill_addr_q <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      fill_req_q  <= fill_req_d;
      fill_addr_q <= fill_addr_d;
      pend_q      <= pend_d;
    end
  end

  assign ImemFillReq  = fill_req_q;
  assign ImemFillAddr = fill_addr_q;

endmodule
